// File: rtl/fnd_time_scanner.sv
// 4-digit common-anode FND scanner: frame-coherent snapshot of the time
// fields, binary-to-7-segment decode, blinking decimal point on digit 2.
module fnd_time_scanner #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_time_mode,
    input  logic       blank,
    input  logic [6:0] msec,
    input  logic [6:0] sec,
    input  logic [6:0] min,
    input  logic [6:0] hour,
    output logic [3:0] fnd_comm,
    output logic [7:0] fnd_font
);

    localparam int            DIV  = CLK_HZ / SCAN_HZ;
    localparam int            DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [1:0]    idx;
    logic          primed;

    logic          snap_mode;
    logic [6:0]    snap_msec, snap_sec, snap_min, snap_hour;
    logic          src_mode;
    logic [6:0]    src_msec, src_sec, src_min, src_hour;
    logic [6:0]    pair_val, digit_val;
    logic [7:0]    font_next;

    function automatic logic [7:0] seg7(input logic [6:0] d);
        case (d)
            7'd0:    seg7 = 8'hC0;
            7'd1:    seg7 = 8'hF9;
            7'd2:    seg7 = 8'hA4;
            7'd3:    seg7 = 8'hB0;
            7'd4:    seg7 = 8'h99;
            7'd5:    seg7 = 8'h92;
            7'd6:    seg7 = 8'h82;
            7'd7:    seg7 = 8'hF8;
            7'd8:    seg7 = 8'h80;
            7'd9:    seg7 = 8'h90;
            default: seg7 = 8'hBF;
        endcase
    endfunction

    assign tick = (div_cnt == LAST);

    // Scan-rate divider; wraps to zero on the terminal count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DW'(1);
    end

    // Digit index advance; primed marks that the first tick has happened
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx    <= 2'd0;
            primed <= 1'b0;
        end else if (tick) begin
            idx    <= idx + 2'd1;
            primed <= 1'b1;
        end
    end

    // Snapshot at the frame boundary (last digit going out) and on the first tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_mode <= 1'b0;
            snap_msec <= '0;
            snap_sec  <= '0;
            snap_min  <= '0;
            snap_hour <= '0;
        end else if (tick && (idx == 2'd3 || !primed)) begin
            snap_mode <= sw_time_mode;
            snap_msec <= msec;
            snap_sec  <= sec;
            snap_min  <= min;
            snap_hour <= hour;
        end
    end

    // Decode the current digit; the very first digit after reset bypasses the
    // snapshot so it shows the same values that get latched on that tick
    always_comb begin
        src_mode = primed ? snap_mode : sw_time_mode;
        src_msec = primed ? snap_msec : msec;
        src_sec  = primed ? snap_sec  : sec;
        src_min  = primed ? snap_min  : min;
        src_hour = primed ? snap_hour : hour;

        pair_val  = idx[1] ? (src_mode ? src_hour : src_sec)
                           : (src_mode ? src_min  : src_msec);
        digit_val = idx[0] ? (pair_val / 7'd10) : (pair_val % 7'd10);
        font_next = (pair_val > 7'd99) ? 8'hBF : seg7(digit_val);
        if (idx == 2'd2 && src_msec < 7'd50) font_next[7] = 1'b0;
    end

    // Registered outputs; comm and font always move together on the tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fnd_comm <= 4'b1111;
            fnd_font <= 8'hFF;
        end else if (tick) begin
            if (blank) begin
                fnd_comm <= 4'b1111;
                fnd_font <= 8'hFF;
            end else begin
                fnd_comm <= ~(4'b0001 << idx);
                fnd_font <= font_next;
            end
        end
    end

endmodule

// File: tb/tb_fnd_time_scanner.sv
// Bench for fnd_time_scanner: queue scoreboard fed by a behavioural model,
// plus directed frame checks against hand-derived segment codes.
module tb_fnd_time_scanner;

    localparam int TB_DIV = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw_time_mode = 1'b0;
    logic       blank = 1'b0;
    logic [6:0] msec = '0, sec = '0, min = '0, hour = '0;
    logic [3:0] fnd_comm;
    logic [7:0] fnd_font;

    int errs = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [3:0] comm_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    logic [11:0] q[$];
    logic [11:0] cur = 12'hFFF;

    int         m_cnt, m_idx;
    bit         m_primed;
    bit         s_mode;
    logic [6:0] s_msec, s_sec, s_min, s_hour;

    fnd_time_scanner #(.CLK_HZ(100), .SCAN_HZ(10)) dut (
        .clk(clk), .reset(reset), .sw_time_mode(sw_time_mode), .blank(blank),
        .msec(msec), .sec(sec), .min(min), .hour(hour),
        .fnd_comm(fnd_comm), .fnd_font(fnd_font)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_font(int d, bit mode, int ms, int s, int mn, int h);
        int v;
        logic [7:0] f;
        if (d < 2) v = mode ? mn : ms;
        else       v = mode ? h : s;
        if (v > 99) f = 8'hBF;
        else        f = seg_tab[(d % 2 == 0) ? (v % 10) : (v / 10)];
        if (d == 2 && ms < 50) f[7] = 1'b0;
        return f;
    endfunction

    // Reference model: pushes the expected output word on every scan tick
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt    <= 0;
            m_idx    <= 0;
            m_primed <= 1'b0;
            s_mode   <= 1'b0;
            s_msec   <= '0;
            s_sec    <= '0;
            s_min    <= '0;
            s_hour   <= '0;
            q.delete();
            q.push_back(12'hFFF);
        end else if (m_cnt == TB_DIV - 1) begin
            if (blank)
                q.push_back(12'hFFF);
            else if (!m_primed)
                q.push_back({comm_tab[m_idx], exp_font(m_idx, sw_time_mode, msec, sec, min, hour)});
            else
                q.push_back({comm_tab[m_idx], exp_font(m_idx, s_mode, s_msec, s_sec, s_min, s_hour)});
            if (m_idx == 3 || !m_primed) begin
                s_mode <= sw_time_mode;
                s_msec <= msec;
                s_sec  <= sec;
                s_min  <= min;
                s_hour <= hour;
            end
            m_primed <= 1'b1;
            m_idx    <= (m_idx + 1) % 4;
            m_cnt    <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Scoreboard monitor: outputs must equal the latest expected word every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0) begin
                cur <= q[0];
                check("sb", {fnd_comm, fnd_font}, q[0]);
                q.delete(0);
            end else begin
                check("sb", {fnd_comm, fnd_font}, cur);
            end
        end
    end

    task automatic set_in(input bit mode, input int ms, input int s, input int mn, input int h);
        @(negedge clk); #1;
        sw_time_mode = mode;
        msec = 7'(ms);
        sec  = 7'(s);
        min  = 7'(mn);
        hour = 7'(h);
    endtask

    task automatic sync_d0();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fnd_comm != 4'b1110 && n < 60);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] f0, input logic [7:0] f1,
                               input logic [7:0] f2, input logic [7:0] f3);
        logic [7:0] fs [4];
        fs = '{f0, f1, f2, f3};
        sync_d0();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (TB_DIV) @(negedge clk);
            check(tag, {fnd_comm, fnd_font}, {comm_tab[k], fs[k]});
        end
    endtask

    initial begin
        int n;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        #1 check("rst", {fnd_comm, fnd_font}, 12'hFFF);
        reset = 1'b1;

        // First tick shows digit 0 of all-zero inputs
        n = 0;
        do begin @(negedge clk); n++; end while (fnd_comm == 4'b1111 && n < 20);
        check("first", {fnd_comm, fnd_font}, {4'hE, 8'hC0});
        check("first_lat", 12'(n), 12'd10);

        set_in(1'b0, 37, 45, 0, 0);
        repeat (40) @(negedge clk);
        check_frame("m0_dp", 8'hF8, 8'hB0, 8'h12, 8'h99);

        set_in(1'b0, 73, 45, 0, 0);
        repeat (40) @(negedge clk);
        check_frame("m0_nodp", 8'hB0, 8'hF8, 8'h92, 8'h99);

        set_in(1'b1, 10, 0, 59, 23);
        repeat (40) @(negedge clk);
        check_frame("m1", 8'h90, 8'h92, 8'h30, 8'hA4);

        // Mid-frame change must not tear the current frame
        set_in(1'b0, 0, 12, 8, 7);
        repeat (40) @(negedge clk);
        sync_d0();
        check("mid_d0", {fnd_comm, fnd_font}, {4'hE, 8'hC0});
        repeat (TB_DIV) @(negedge clk);
        check("mid_d1", {fnd_comm, fnd_font}, {4'hD, 8'hC0});
        #1 sec = 7'd34; sw_time_mode = 1'b1;
        repeat (TB_DIV) @(negedge clk);
        check("mid_d2", {fnd_comm, fnd_font}, {4'hB, 8'h24});
        repeat (TB_DIV) @(negedge clk);
        check("mid_d3", {fnd_comm, fnd_font}, {4'h7, 8'hF9});
        repeat (TB_DIV) @(negedge clk);
        check("new_d0", {fnd_comm, fnd_font}, {4'hE, 8'h80});
        repeat (TB_DIV) @(negedge clk);
        check("new_d1", {fnd_comm, fnd_font}, {4'hD, 8'hC0});
        repeat (TB_DIV) @(negedge clk);
        check("new_d2", {fnd_comm, fnd_font}, {4'hB, 8'h78});
        repeat (TB_DIV) @(negedge clk);
        check("new_d3", {fnd_comm, fnd_font}, {4'h7, 8'hC0});

        // Blank for two frames, then release (scoreboard checks the resume index)
        @(negedge clk); #1 blank = 1'b1;
        repeat (80) @(negedge clk);
        check("blank", {fnd_comm, fnd_font}, 12'hFFF);
        repeat (15) @(negedge clk);
        check("blank2", {fnd_comm, fnd_font}, 12'hFFF);
        #1 blank = 1'b0;
        repeat (30) @(negedge clk);

        // Out-of-range msec shows dashes on its pair, dp off
        set_in(1'b0, 120, 45, 0, 0);
        repeat (40) @(negedge clk);
        check_frame("oor", 8'hBF, 8'hBF, 8'h92, 8'h99);

        // Reset mid-frame: immediate reset values, restart after a full period
        repeat (15) @(negedge clk);
        #1 reset = 1'b0;
        #1 check("rst_mid", {fnd_comm, fnd_font}, 12'hFFF);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (fnd_comm == 4'b1111 && n < 20);
        check("restart_lat", 12'(n), 12'd10);
        check("restart", {fnd_comm, fnd_font}, {4'hE, 8'hBF});
        repeat (50) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
